// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite command master: response codes,
// FSM state encoding and the latency counter width.
package axi_lite_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axi_lite_sat_counter.sv
// Clearable, saturating cycle counter used to measure command latency.
module axi_lite_sat_counter
    import axi_lite_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_count <= '0;
        else if (i_en && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one command into one AXI read or
// write and returns the slave response plus the measured latency.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              axi_lite_aclk,
    input  logic              axi_lite_areset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [CNT_W-1:0]  rsp_cycles,

    output logic [ADDR_W-1:0] axi_lite_araddr,
    output logic              axi_lite_arvalid,
    input  logic              axi_lite_arready,
    input  logic [DATA_W-1:0] axi_lite_rdata,
    input  logic [1:0]        axi_lite_rresp,
    input  logic              axi_lite_rvalid,
    output logic              axi_lite_rready,
    output logic [ADDR_W-1:0] axi_lite_awaddr,
    output logic              axi_lite_awvalid,
    input  logic              axi_lite_awready,
    output logic [DATA_W-1:0] axi_lite_wdata,
    output logic              axi_lite_wvalid,
    input  logic              axi_lite_wready,
    input  logic [1:0]        axi_lite_bresp,
    input  logic              axi_lite_bvalid,
    output logic              axi_lite_bready
);

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_arvalid;
    logic                r_rready;
    logic [ADDR_W-1:0]   r_awaddr;
    logic                r_awvalid;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wvalid;
    logic                r_bready;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_cnt_en;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_aw_hs  = r_awvalid && axi_lite_awready;
    assign w_w_hs   = r_wvalid && axi_lite_wready;
    // Count every bus-facing cycle, including the one carrying the B/R handshake.
    assign w_cnt_en = (r_state != IDLE) && (r_state != RSP);

    axi_lite_sat_counter u_cycles (
        .i_clk   (axi_lite_aclk),
        .i_rst   (axi_lite_areset),
        .i_clr   (w_accept),
        .i_en    (w_cnt_en),
        .o_count (rsp_cycles)
    );

    always_ff @(posedge axi_lite_aclk) begin
        if (axi_lite_areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    // A channel whose valid is already low has completed earlier.
                    if ((w_aw_hs || !r_awvalid) && (w_w_hs || !r_wvalid)) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_lite_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= axi_lite_bresp;
                        r_state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (axi_lite_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_lite_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= axi_lite_rdata;
                        r_rsp_resp  <= axi_lite_rresp;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready        = r_cmd_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_write        = r_rsp_write;
    assign rsp_rdata        = r_rsp_rdata;
    assign rsp_resp         = r_rsp_resp;
    assign axi_lite_araddr  = r_araddr;
    assign axi_lite_arvalid = r_arvalid;
    assign axi_lite_rready  = r_rready;
    assign axi_lite_awaddr  = r_awaddr;
    assign axi_lite_awvalid = r_awvalid;
    assign axi_lite_wdata   = r_wdata;
    assign axi_lite_wvalid  = r_wvalid;
    assign axi_lite_bready  = r_bready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small delay-configurable slave
// that reacts on the falling edge.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] rsp_cycles;
    logic [31:0] araddr, rdata = '0, awaddr, wdata;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready;
    logic [1:0]  rresp = '0, bresp = '0;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .axi_lite_aclk(clk), .axi_lite_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
        .axi_lite_araddr(araddr), .axi_lite_arvalid(arvalid), .axi_lite_arready(arready),
        .axi_lite_rdata(rdata), .axi_lite_rresp(rresp), .axi_lite_rvalid(rvalid),
        .axi_lite_rready(rready),
        .axi_lite_awaddr(awaddr), .axi_lite_awvalid(awvalid), .axi_lite_awready(awready),
        .axi_lite_wdata(wdata), .axi_lite_wvalid(wvalid), .axi_lite_wready(wready),
        .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid), .axi_lite_bready(bready)
    );

    int total = 0;
    int bad   = 0;

    // slave configuration and observation
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0]  r_resp_cfg = 2'd0;
    bit          b_hold = 1'b0;
    logic [31:0] mem [4];
    logic [31:0] ar_seen = '0;
    int          aw_hs_n = 0, wv_hi_n = 0, rsp_hs_n = 0;

    logic        p_awv = 1'b0, p_wv = 1'b0, p_bready = 1'b0, p_arv = 1'b0, p_rready = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    bit          aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] wa = '0, wd = '0;
    int          awc = 0, wc = 0, arc = 0, b_cd = 0;

    initial for (int i = 0; i < 4; i++) mem[i] = '0;

    // DUT outputs only move on posedge, so the previous negedge values are
    // exactly what the posedge handshake saw.
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_got = 0; w_got = 0; awc = 0; wc = 0; arc = 0; b_cd = 0;
        end else begin
            if (bvalid && p_bready) bvalid = 0;
            if (rvalid && p_rready) rvalid = 0;
            if (b_cd > 0) begin
                b_cd--;
                if (b_cd == 0) begin bvalid = 1; bresp = 2'd0; end
            end
            if (awready && p_awv) begin aw_got = 1; wa = p_awaddr; aw_hs_n++; end
            if (wready && p_wv) begin w_got = 1; wd = p_wdata; end
            if (aw_got && w_got) begin
                mem[wa[3:2]] = wd; aw_got = 0; w_got = 0;
                if (!b_hold) b_cd = 1;
            end
            if (arready && p_arv) begin
                ar_seen = p_araddr; rvalid = 1; rdata = mem[p_araddr[3:2]]; rresp = r_resp_cfg;
            end
            awready = awvalid && (awc >= aw_dly); awc = awvalid ? awc + 1 : 0;
            wready  = wvalid  && (wc >= w_dly);   wc  = wvalid  ? wc + 1  : 0;
            arready = arvalid && (arc >= ar_dly); arc = arvalid ? arc + 1 : 0;
        end
        if (wvalid) wv_hi_n++;
        p_awv = awvalid; p_wv = wvalid; p_bready = bready; p_arv = arvalid; p_rready = rready;
        p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
    end

    always @(posedge clk) if (rsp_valid && rsp_ready) rsp_hs_n++;

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready} !== 7'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0000000",
                {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready});
        end
        total++;
        if (rsp_cycles !== 16'd0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", rsp_cycles); end
        rst = 0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_zero_wait_write();
        bit ok;
        aw_dly = 0; w_dly = 0;
        issue(1'b1, 32'h0000_0000, 32'h5a5a_4b4b);
        wait_rsp(20, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL zw_write_timeout got=no_rsp want=rsp"); end
        total++;
        if ({rsp_write, rsp_resp} !== 3'b100) begin
            bad++; $display("FAIL zw_write_fields got=%b want=100", {rsp_write, rsp_resp});
        end
        total++;
        if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL zw_write_rdata got=%h want=0", rsp_rdata); end
        total++;
        if (rsp_cycles !== 16'd3) begin bad++; $display("FAIL zw_write_cycles got=%0d want=3", rsp_cycles); end
        take_rsp();
        total++;
        if (mem[0] !== 32'h5a5a_4b4b) begin bad++; $display("FAIL zw_write_mem got=%h want=5a5a4b4b", mem[0]); end
    endtask

    task automatic test_w_late();
        bit ok;
        int hs0;
        aw_dly = 0; w_dly = 4;
        aw_hs_n = 0; wv_hi_n = 0; hs0 = rsp_hs_n;
        issue(1'b1, 32'h0000_0004, 32'h5b5b_4a4a);
        wait_rsp(40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wlate_timeout got=no_rsp want=rsp"); end
        total++;
        if (aw_hs_n !== 1) begin bad++; $display("FAIL wlate_aw_count got=%0d want=1", aw_hs_n); end
        total++;
        if (wv_hi_n !== 5) begin bad++; $display("FAIL wlate_wvalid_held got=%0d want=5", wv_hi_n); end
        total++;
        if (rsp_resp !== 2'd0) begin bad++; $display("FAIL wlate_resp got=%0d want=0", rsp_resp); end
        total++;
        if (rsp_cycles !== 16'd7) begin bad++; $display("FAIL wlate_cycles got=%0d want=7", rsp_cycles); end
        take_rsp();
        repeat (4) @(negedge clk);
        total++;
        if (rsp_hs_n - hs0 !== 1) begin bad++; $display("FAIL wlate_single_rsp got=%0d want=1", rsp_hs_n - hs0); end
        total++;
        if (mem[1] !== 32'h5b5b_4a4a) begin bad++; $display("FAIL wlate_mem got=%h want=5b5b4a4a", mem[1]); end
        w_dly = 0;
    endtask

    task automatic test_read();
        bit ok;
        issue(1'b0, 32'h0000_0000, 32'hdead_beef);
        wait_rsp(20, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL read0_timeout got=no_rsp want=rsp"); end
        total++;
        if (ar_seen !== 32'h0) begin bad++; $display("FAIL read0_araddr got=%h want=0", ar_seen); end
        total++;
        if (rsp_rdata !== 32'h5a5a_4b4b) begin bad++; $display("FAIL read0_rdata got=%h want=5a5a4b4b", rsp_rdata); end
        total++;
        if ({rsp_write, rsp_resp} !== 3'b000) begin
            bad++; $display("FAIL read0_fields got=%b want=000", {rsp_write, rsp_resp});
        end
        total++;
        if (rsp_cycles !== 16'd2) begin bad++; $display("FAIL read0_cycles got=%0d want=2", rsp_cycles); end
        take_rsp();
        issue(1'b0, 32'h0000_0004, 32'h0);
        wait_rsp(20, ok);
        total++;
        if (!ok || ar_seen !== 32'h4 || rsp_rdata !== 32'h5b5b_4a4a) begin
            bad++; $display("FAIL read4 got=%h/%h want=4/5b5b4a4a", ar_seen, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_rresp_backpressure();
        bit ok;
        r_resp_cfg = 2'b10;
        issue(1'b0, 32'h0000_0004, 32'h0);
        wait_rsp(20, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout got=no_rsp want=rsp"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, cmd_ready, rsp_write, rsp_resp} !== 5'b10010 ||
                rsp_rdata !== 32'h5b5b_4a4a || rsp_cycles !== 16'd2) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d want=10010/5b5b4a4a/2", i,
                    {rsp_valid, cmd_ready, rsp_write, rsp_resp}, rsp_rdata, rsp_cycles);
            end
            @(negedge clk);
        end
        take_rsp();
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release got=%b want=01", {rsp_valid, cmd_ready});
        end
        r_resp_cfg = 2'b00;
    endtask

    task automatic test_reset_midflight();
        bit seen;
        int hs0;
        b_hold = 1; hs0 = rsp_hs_n; seen = 0;
        issue(1'b1, 32'h0000_0008, 32'h1234_5678);
        for (int i = 0; i < 20; i++) begin
            if (bready) begin seen = 1; break; end
            @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_wr_resp_timeout got=no_bready want=bready"); end
        rst = 1;
        @(negedge clk);
        total++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin
            bad++; $display("FAIL mid_reset_outputs got=%b want=0000000",
                {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
        end
        rst = 0; b_hold = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b10 || rsp_hs_n != hs0) begin
            bad++; $display("FAIL mid_release got=%b hs=%0d want=10 hs=%0d", {cmd_ready, rsp_valid}, rsp_hs_n, hs0);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        ar_dly = 70000;
        issue(1'b0, 32'h0000_0000, 32'h0);
        wait_rsp(70100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL sat_timeout got=no_rsp want=rsp"); end
        total++;
        if (rsp_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_cycles got=%h want=ffff", rsp_cycles); end
        total++;
        if (rsp_rdata !== 32'h5a5a_4b4b || rsp_resp !== 2'd0) begin
            bad++; $display("FAIL sat_data got=%h/%0d want=5a5a4b4b/0", rsp_rdata, rsp_resp);
        end
        take_rsp();
        ar_dly = 0;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL sat_idle got=%b want=1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_w_late();
        test_read();
        test_rresp_backpressure();
        test_reset_midflight();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the AXI-Lite and command address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the AXI-Lite and command data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- axi_lite_aclk  in  1  clock; all logic on rising edge.
- axi_lite_areset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have the command port:
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data, ignored for reads.
REQ-005 The block SHALL have the response port:
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  bresp/rresp from slave.
- rsp_cycles  out  16  cycles from command acceptance to bus response handshake, saturating.
REQ-006 The block SHALL have the AXI-Lite master port:
- axi_lite_araddr, axi_lite_arvalid  out; axi_lite_arready  in.
- axi_lite_rdata, axi_lite_rresp, axi_lite_rvalid  in; axi_lite_rready  out.
- axi_lite_awaddr, axi_lite_awvalid  out; axi_lite_awready  in.
- axi_lite_wdata, axi_lite_wvalid  out; axi_lite_wready  in.
- axi_lite_bresp, axi_lite_bvalid  in; axi_lite_bready  out.
- Widths: addresses ADDR_W, data DATA_W, resp 2.

Function
REQ-007 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; exactly one transaction is in flight.
REQ-008 cmd_ready SHALL be 1 only in IDLE and SHALL NOT depend combinationally on cmd_valid.
REQ-009 On cmd_valid&&cmd_ready the block SHALL latch addr/wdata/write; the next cycle SHALL be WR_REQ (write) or RD_REQ (read).
REQ-010 In WR_REQ, awvalid and wvalid SHALL both be asserted from the first cycle, each registered and dropped independently on its own handshake.
REQ-011 The FSM SHALL go to WR_RESP once both AW and W have handshaken, in any order or in the same cycle.
REQ-012 bready SHALL be 1 in WR_RESP. On bvalid&&bready the block SHALL capture bresp and go to RSP.
REQ-013 In RD_REQ, arvalid SHALL be 1 until arready, then the FSM SHALL go to RD_DATA.
REQ-014 rready SHALL be 1 in RD_DATA. On rvalid&&rready the block SHALL capture rdata/rresp and go to RSP.
REQ-015 Once asserted, every AXI valid SHALL stay high, with address/data stable, until its handshake; no timeouts or aborts.
REQ-016 rsp_valid SHALL be 1 in RSP with fields stable. On rsp_ready the FSM SHALL return to IDLE; backpressure SHALL be held indefinitely.
REQ-017 The cycle counter SHALL clear on command acceptance and increment every cycle until the B/R handshake inclusive.
- The counter SHALL saturate at 16'hFFFF.
- Minimum value with a zero-wait slave SHALL be 2.
REQ-018 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-019 While axi_lite_areset=1 at a clock edge, the block SHALL force state IDLE and all outputs to 0, except cmd_ready, which SHALL be 1 from the first cycle after reset deasserts.
REQ-020 Reset mid-transaction SHALL abandon the transaction without emitting a response; AXI valids SHALL drop on the next edge.

Structure
REQ-021 Package axi_lite_pkg SHALL hold the resp codes OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3, the FSM state encoding, and the counter width 16.
REQ-022 Sub-module axi_lite_sat_counter (clear, enable, saturating 16-bit) SHALL implement rsp_cycles; all other logic SHALL be a single FSM.

Verification
REQ-023 Zero-wait write, addr 0x0000_0000, data 0x5a5a_4b4b, slave accepts AW and W together -> rsp_write=1, rsp_resp=0, rsp_rdata=0, rsp_cycles=3.
REQ-024 Write addr 0x0000_0004, data 0x5b5b_4a4a, wready 4 cycles after awready -> AW handshakes once, wvalid held, single response, rsp_resp=0.
REQ-025 Read addr 0x0000_0000 after REQ-023 -> araddr=0, rsp_rdata=0x5a5a_4b4b, rsp_resp=0, rsp_write=0.
REQ-026 Slave returns rresp=2'b10; rsp_ready low 5 cycles -> rsp_resp=2, rsp_valid and fields stable 5 cycles, cmd_ready=0 throughout.
REQ-027 Reset pulse during WR_RESP with bvalid never asserted -> all valids 0 next cycle, no rsp_valid, cmd_ready=1 after release.
REQ-028 Slave stalls arready 70000 cycles -> rsp_cycles=16'hFFFF, transaction completes normally.
